// File: rtl/serial_frame_pkg.sv
// Shared types and constants for the serial frame transmitter.
// frame_len gives the cycle count from the accepting edge to the DONE edge.
package serial_frame_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } tx_state_t;

   localparam logic IDLE_LEVEL  = 1'b1;
   localparam logic START_LEVEL = 1'b0;
   localparam logic STOP_LEVEL  = 1'b1;

   function automatic int frame_len(input int data_w, input int parity_en, input int clks_per_bit);
      return (data_w + parity_en + 2) * clks_per_bit;
   endfunction

endpackage

// File: rtl/serial_frame_tx_bit_timer.sv
// Bit-period timer: TICK is high on the last cycle of each bit period.
// RELOAD starts a fresh period; with CLKS_PER_BIT=1 TICK is always high.
module bit_timer #(
   parameter int CLKS_PER_BIT = 4
) (
   input  logic CLK,
   input  logic RST,
   input  logic RELOAD,
   output logic TICK
);

   localparam int CNT_W = $clog2(CLKS_PER_BIT + 1);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

   logic [CNT_W-1:0] r_cnt;

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_cnt <= '0;
      end else if (RELOAD) begin
         r_cnt <= LAST;
      end else if (r_cnt != '0) begin
         r_cnt <= r_cnt - 1'b1;
      end
   end

   assign TICK = (r_cnt == '0);

endmodule

// File: rtl/serial_frame_tx.sv
// Serial frame transmitter: start bit, DATA_W bits LSB first, optional parity, stop bit.
// TXD is registered; each bit is held for CLKS_PER_BIT clocks.
module serial_frame_tx
   import serial_frame_pkg::*;
#(
   parameter int DATA_W       = 8,
   parameter int CLKS_PER_BIT = 4,
   parameter int PARITY_EN    = 1,
   parameter int PARITY_ODD   = 0
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic [DATA_W-1:0] D,
   input  logic              LOAD,
   output logic              READY,
   output logic              TXD,
   output logic              BUSY,
   output logic              DONE
);

   localparam int IDX_W = $clog2(DATA_W + 1);

   tx_state_t         r_state;
   tx_state_t         w_next_state;
   logic [DATA_W-1:0] r_shreg;
   logic [IDX_W-1:0]  r_bit_idx;
   logic              r_parity;
   logic              r_txd;
   logic              r_done;
   logic              w_tick;
   logic              w_reload;
   logic              w_last_bit;

   assign w_last_bit = (r_bit_idx == IDX_W'(DATA_W - 1));

   // Timer restarts on acceptance and on every bit boundary that stays inside the frame
   assign w_reload = (r_state == IDLE) ? LOAD : (w_tick && (w_next_state != IDLE));

   bit_timer #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_bit_timer (
      .CLK   (CLK),
      .RST   (RST),
      .RELOAD(w_reload),
      .TICK  (w_tick)
   );

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         IDLE:    if (LOAD) w_next_state = START;
         START:   if (w_tick) w_next_state = DATA;
         DATA:    if (w_tick && w_last_bit) w_next_state = (PARITY_EN != 0) ? PARITY : STOP;
         PARITY:  if (w_tick) w_next_state = STOP;
         STOP:    if (w_tick) w_next_state = IDLE;
         default: w_next_state = IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_shreg   <= '0;
         r_bit_idx <= '0;
         r_parity  <= 1'b0;
         r_txd     <= IDLE_LEVEL;
         r_done    <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            IDLE: begin
               if (LOAD) begin
                  r_shreg   <= D;
                  r_parity  <= (^D) ^ (PARITY_ODD != 0);
                  r_bit_idx <= '0;
                  r_txd     <= START_LEVEL;
               end
            end
            START: begin
               if (w_tick) begin
                  r_txd   <= r_shreg[0];
                  r_shreg <= r_shreg >> 1;
               end
            end
            DATA: begin
               if (w_tick) begin
                  if (w_last_bit) begin
                     r_txd <= (PARITY_EN != 0) ? r_parity : STOP_LEVEL;
                  end else begin
                     r_txd     <= r_shreg[0];
                     r_shreg   <= r_shreg >> 1;
                     r_bit_idx <= r_bit_idx + 1'b1;
                  end
               end
            end
            PARITY: begin
               if (w_tick) r_txd <= STOP_LEVEL;
            end
            STOP: begin
               if (w_tick) begin
                  r_txd  <= IDLE_LEVEL;
                  r_done <= 1'b1;
               end
            end
            default: r_txd <= IDLE_LEVEL;
         endcase
      end
   end

   assign READY = (r_state == IDLE);
   assign BUSY  = ~READY;
   assign TXD   = r_txd;
   assign DONE  = r_done;

endmodule

// File: tb/tb_serial_frame_tx.sv
// Bench for serial_frame_tx: three parameter variants share one stimulus stream
// and are compared every cycle against a frame-level reference model.
module tb_serial_frame_tx;
   import serial_frame_pkg::*;

   localparam int DW = 8;

   logic       clk = 1'b0;
   logic       rst;
   logic       ld;
   logic [7:0] d;
   logic [2:0] rdy, txd, bsy, dn;

   int cpb [3] = '{4, 4, 1};
   int pen [3] = '{1, 1, 0};
   int podd[3] = '{0, 1, 0};

   bit         m_busy[3];
   bit         m_done[3];
   int         m_cnt [3];
   logic [7:0] m_data[3];
   int         d_done[3];
   int         acc_cyc[$];
   int         cyc;
   int         n_chk;
   int         n_fail;

   always #5 clk = ~clk;

   serial_frame_tx #(.DATA_W(8), .CLKS_PER_BIT(4), .PARITY_EN(1), .PARITY_ODD(0)) u_even (
      .CLK(clk), .RST(rst), .D(d), .LOAD(ld), .READY(rdy[0]), .TXD(txd[0]), .BUSY(bsy[0]), .DONE(dn[0]));
   serial_frame_tx #(.DATA_W(8), .CLKS_PER_BIT(4), .PARITY_EN(1), .PARITY_ODD(1)) u_odd (
      .CLK(clk), .RST(rst), .D(d), .LOAD(ld), .READY(rdy[1]), .TXD(txd[1]), .BUSY(bsy[1]), .DONE(dn[1]));
   serial_frame_tx #(.DATA_W(8), .CLKS_PER_BIT(1), .PARITY_EN(0), .PARITY_ODD(0)) u_fast (
      .CLK(clk), .RST(rst), .D(d), .LOAD(ld), .READY(rdy[2]), .TXD(txd[2]), .BUSY(bsy[2]), .DONE(dn[2]));

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s at cycle %0d: got %0h, expected %0h", tag, cyc, obs, exp);
      end
   endtask

   // Line level expected k cycles after the accepting edge
   function automatic logic exp_bit(input logic [7:0] w, input int k, input int c, input int pe, input int po);
      int b;
      b = k / c;
      if (b == 0) return 1'b0;
      if (b <= DW) return w[b-1];
      if (pe != 0 && b == DW + 1) return (^w) ^ (po != 0);
      return 1'b1;
   endfunction

   task automatic cycle();
      if (rdy[0] && ld && !rst) acc_cyc.push_back(cyc + 1);
      @(posedge clk);
      cyc++;
      for (int i = 0; i < 3; i++) begin
         if (rst) begin
            m_busy[i] = 1'b0;
            m_done[i] = 1'b0;
         end else begin
            m_done[i] = 1'b0;
            if (m_busy[i]) begin
               m_cnt[i]++;
               if (m_cnt[i] == frame_len(DW, pen[i], cpb[i])) begin
                  m_busy[i] = 1'b0;
                  m_done[i] = 1'b1;
               end
            end else if (ld) begin
               m_busy[i] = 1'b1;
               m_cnt[i]  = 0;
               m_data[i] = d;
            end
         end
      end
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         check_val($sformatf("txd%0d", i), 32'(txd[i]),
                   m_busy[i] ? 32'(exp_bit(m_data[i], m_cnt[i], cpb[i], pen[i], podd[i])) : 32'd1);
         check_val($sformatf("ready%0d", i), 32'(rdy[i]), 32'(!m_busy[i]));
         check_val($sformatf("busy%0d", i), 32'(bsy[i]), 32'(m_busy[i]));
         check_val($sformatf("done%0d", i), 32'(dn[i]), 32'(m_done[i]));
         if (dn[i]) d_done[i]++;
      end
   endtask

   task automatic clear_counts();
      for (int i = 0; i < 3; i++) d_done[i] = 0;
      acc_cyc.delete();
   endtask

   initial begin
      n_chk = 0;
      n_fail = 0;
      cyc = 0;
      rst = 1'b1;
      ld = 1'b0;
      d = 8'h00;
      for (int i = 0; i < 3; i++) begin
         m_busy[i] = 1'b0;
         m_done[i] = 1'b0;
         m_cnt[i] = 0;
         m_data[i] = 8'h00;
      end
      clear_counts();

      // Reset and idle hold
      repeat (2) cycle();
      rst = 1'b0;
      repeat (10) cycle();

      // Single frame 8'hA5 (even and odd parity variants side by side)
      d = 8'hA5; ld = 1'b1;
      cycle();
      ld = 1'b0; d = 8'($urandom);
      repeat (50) cycle();
      check_val("t2_done_even", d_done[0], 1);
      check_val("t2_done_odd", d_done[1], 1);

      // LOAD while busy is ignored
      clear_counts();
      d = 8'h3C; ld = 1'b1;
      cycle();
      ld = 1'b0;
      repeat (9) cycle();
      d = 8'hFF; ld = 1'b1;
      cycle();
      ld = 1'b0;
      repeat (45) cycle();
      check_val("t3_one_done", d_done[0], 1);

      // Back-to-back with LOAD held high
      clear_counts();
      d = 8'h01; ld = 1'b1;
      for (int k = 0; k < 120 && acc_cyc.size() < 2; k++) begin
         cycle();
         if (acc_cyc.size() == 1) d = 8'h80;
      end
      ld = 1'b0;
      check_val("t4_accepts", acc_cyc.size(), 2);
      if (acc_cyc.size() >= 2) check_val("t4_gap", acc_cyc[1] - acc_cyc[0], 45);
      repeat (50) cycle();
      check_val("t4_dones", d_done[0], 2);

      // Reset in the middle of the data bits
      clear_counts();
      d = 8'hF0; ld = 1'b1;
      cycle();
      ld = 1'b0;
      repeat (19) cycle();
      rst = 1'b1;
      cycle();
      rst = 1'b0;
      repeat (3) cycle();
      check_val("t5_no_done", d_done[0], 0);
      d = 8'h0F; ld = 1'b1;
      cycle();
      ld = 1'b0;
      repeat (46) cycle();
      check_val("t5_new_frame_done", d_done[0], 1);

      // Short frame on the no-parity, one-clock-per-bit variant
      clear_counts();
      d = 8'h96; ld = 1'b1;
      cycle();
      ld = 1'b0;
      repeat (12) cycle();
      check_val("t6_fast_done", d_done[2], 1);
      repeat (40) cycle();

      // Randomized traffic with occasional resets
      for (int k = 0; k < 600; k++) begin
         ld  = ($urandom_range(0, 3) == 0);
         d   = 8'($urandom);
         rst = ($urandom_range(0, 149) == 0);
         cycle();
      end
      rst = 1'b0;
      ld = 1'b0;
      repeat (50) cycle();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
